// File: rtl/minrv32_pkg.sv
// Shared types and constants for the minrv32 bus sequencer.
// Holds the state encoding, the reset instruction and the memory request bundle.
package minrv32_pkg;

  typedef enum logic [2:0] {
    StResetWait,
    StFetch,
    StDecode,
    StData,
    StCommit,
    StHalt
  } seq_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } mem_req_t;

endpackage

// File: rtl/minrv32_wait_timer.sv
// Per-request wait counter with an optional timeout compare.
// A TIMEOUT_CYCLES of zero disables the timeout; the counter then just wraps.
module minrv32_wait_timer
  import minrv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned WAIT_W         = 10
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic busy_i,
  input  logic ready_i,
  output logic timeout_o
);

  logic [WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (busy_i && !ready_i) begin
      count_d = count_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A ready in the compare cycle takes precedence over the timeout.
  assign timeout_o = (TIMEOUT_CYCLES != 0) && busy_i && !ready_i &&
                     (count_q == WAIT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/minrv32_bus_sequencer.sv
// Multi-cycle sequencer sharing one memory port between instruction fetch and
// load/store for the single-cycle minrv32 core; pulses core_step once per commit.
module minrv32_bus_sequencer
  import minrv32_pkg::*;
#(
  parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned WAIT_W         = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] core_pc,
  input  logic        core_mem_valid,
  input  logic [31:0] core_mem_addr,
  input  logic [31:0] core_mem_wdata,
  input  logic [3:0]  core_mem_wstrb,
  input  logic [3:0]  core_mem_rmask,
  input  logic        core_trap,
  output logic [31:0] core_insn,
  output logic [31:0] core_mem_rdata,
  output logic        core_step,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        halted,
  output logic        bus_error,
  output logic [63:0] retired
);

  seq_state_e  state_q, state_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] rdata_q, rdata_d;
  logic [63:0] retired_q, retired_d;
  logic        bus_error_q, bus_error_d;
  logic        first_fetch_q, first_fetch_d;
  logic        timeout;
  logic        wait_clear;
  mem_req_t    req;

  // The full word is latched; byte selection is left to the core.
  logic unused_rmask;
  assign unused_rmask = ^core_mem_rmask;

  minrv32_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .WAIT_W        (WAIT_W)
  ) u_wait_timer (
    .clk_i    (clk),
    .reset_i  (reset),
    .clear_i  (wait_clear),
    .busy_i   (mem_valid),
    .ready_i  (mem_ready),
    .timeout_o(timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StResetWait;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StResetWait: state_d = StFetch;
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StHalt;
        end
      end
      StDecode: begin
        if (core_trap) begin
          state_d = StHalt;
        end else if (core_mem_valid) begin
          state_d = StData;
        end else begin
          state_d = StCommit;
        end
      end
      StData: begin
        if (mem_ready) begin
          state_d = StCommit;
        end else if (timeout) begin
          state_d = StHalt;
        end
      end
      StCommit: state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StResetWait;
    endcase
  end

  always_comb begin
    req       = '0;
    mem_valid = 1'b0;
    core_step = 1'b0;
    halted    = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_valid = 1'b1;
        req.instr = 1'b1;
        req.addr  = first_fetch_q ? PROGADDR_RESET : core_pc;
      end
      StData: begin
        mem_valid = 1'b1;
        req.addr  = core_mem_addr;
        req.wdata = core_mem_wdata;
        req.wstrb = core_mem_wstrb;
      end
      StCommit: core_step = 1'b1;
      StHalt:   halted    = 1'b1;
      default: ;
    endcase
  end

  assign mem_instr = req.instr;
  assign mem_addr  = req.addr;
  assign mem_wdata = req.wdata;
  assign mem_wstrb = req.wstrb;

  // Counter restarts only when a new request phase is entered.
  assign wait_clear = (state_d != state_q) && ((state_d == StFetch) || (state_d == StData));

  always_comb begin
    insn_d        = insn_q;
    rdata_d       = rdata_q;
    retired_d     = retired_q;
    bus_error_d   = bus_error_q | timeout;
    first_fetch_d = first_fetch_q;
    if ((state_q == StFetch) && mem_ready) begin
      insn_d        = mem_rdata;
      first_fetch_d = 1'b0;
    end
    if ((state_q == StData) && mem_ready && (core_mem_wstrb == 4'b0000)) begin
      rdata_d = mem_rdata;
    end
    if (core_step) begin
      retired_d = retired_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      insn_q        <= NOP_INSN;
      rdata_q       <= '0;
      retired_q     <= '0;
      bus_error_q   <= 1'b0;
      first_fetch_q <= 1'b1;
    end else begin
      insn_q        <= insn_d;
      rdata_q       <= rdata_d;
      retired_q     <= retired_d;
      bus_error_q   <= bus_error_d;
      first_fetch_q <= first_fetch_d;
    end
  end

  assign core_insn      = insn_q;
  assign core_mem_rdata = rdata_q;
  assign retired        = retired_q;
  assign bus_error      = bus_error_q;

endmodule

// File: tb/tb_minrv32_bus_sequencer.sv
// Bench for minrv32_bus_sequencer: a behavioural core and memory replay instruction
// tables and check request fields, commit timing, latched data and halting.
module tb_minrv32_bus_sequencer;

  localparam int unsigned TIMEOUT = 4;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int KAlu   = 0;
  localparam int KLoad  = 1;
  localparam int KStore = 2;
  localparam int KTrap  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] core_pc = '0;
  logic        core_mem_valid = 1'b0;
  logic [31:0] core_mem_addr = '0;
  logic [31:0] core_mem_wdata = '0;
  logic [3:0]  core_mem_wstrb = '0;
  logic [3:0]  core_mem_rmask = '0;
  logic        core_trap = 1'b0;
  logic [31:0] core_insn;
  logic [31:0] core_mem_rdata;
  logic        core_step;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        halted;
  logic        bus_error;
  logic [63:0] retired;

  always #5 clk = ~clk;

  minrv32_bus_sequencer #(
    .PROGADDR_RESET(32'h0000_0000),
    .TIMEOUT_CYCLES(TIMEOUT),
    .WAIT_W        (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .core_pc       (core_pc),
    .core_mem_valid(core_mem_valid),
    .core_mem_addr (core_mem_addr),
    .core_mem_wdata(core_mem_wdata),
    .core_mem_wstrb(core_mem_wstrb),
    .core_mem_rmask(core_mem_rmask),
    .core_trap     (core_trap),
    .core_insn     (core_insn),
    .core_mem_rdata(core_mem_rdata),
    .core_step     (core_step),
    .mem_valid     (mem_valid),
    .mem_instr     (mem_instr),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rdata     (mem_rdata),
    .halted        (halted),
    .bus_error     (bus_error),
    .retired       (retired)
  );

  // One program slot: stimulus plus the expected commit gap and load data at commit.
  typedef struct {
    int          kind;
    int          fw;
    int          dw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    int          exp_cycles;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        prog[64];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc, steps, last_step_cyc, waited;
  logic        prev_step;
  logic [31:0] pc;
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_wstrb;
  logic        h_instr;

  function automatic vec_t mk(input int kind, input int fw, input int dw,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic [3:0] wstrb,
                              input int exp_cycles, input logic [31:0] exp_rdata);
    vec_t v;
    v.kind = kind; v.fw = fw; v.dw = dw; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.wstrb = wstrb; v.exp_cycles = exp_cycles; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] insn_word(input int slot);
    return {16'hC0DE, 16'(slot)};
  endfunction

  // Single-cycle core: outputs follow the held instruction and the current PC.
  task automatic drive_core();
    vec_t v;
    core_pc        = pc;
    core_mem_valid = 1'b0;
    core_trap      = 1'b0;
    core_mem_addr  = '0;
    core_mem_wdata = '0;
    core_mem_wstrb = '0;
    core_mem_rmask = '0;
    if (core_insn[31:16] == 16'hC0DE) begin
      v              = prog[int'(core_insn[5:0])];
      core_trap      = (v.kind == KTrap);
      core_mem_valid = (v.kind == KLoad) || (v.kind == KStore);
      core_mem_addr  = v.addr;
      core_mem_wdata = (v.kind == KStore) ? v.wdata : 32'h0;
      core_mem_wstrb = (v.kind == KStore) ? v.wstrb : 4'h0;
      core_mem_rmask = (v.kind == KLoad) ? 4'hF : 4'h0;
    end
  endtask

  task automatic cycle();
    int          need;
    logic [31:0] data;
    logic        rdy;
    @(negedge clk);
    cyc++;
    drive_core();
    #1;
    if (mem_valid) begin
      if (waited == 0) begin
        h_addr = mem_addr; h_wdata = mem_wdata; h_wstrb = mem_wstrb; h_instr = mem_instr;
        if (mem_instr) begin
          check("fetch_addr", mem_addr, 64'(4 * steps));
          check("fetch_wstrb", mem_wstrb, 0);
        end else begin
          check("data_addr", mem_addr, prog[steps].addr);
          check("data_wdata", mem_wdata, (prog[steps].kind == KStore) ? prog[steps].wdata : 0);
          check("data_wstrb", mem_wstrb, (prog[steps].kind == KStore) ? prog[steps].wstrb : 0);
        end
      end else begin
        check("hold_addr_strb", {mem_instr, mem_wstrb, mem_addr}, {h_instr, h_wstrb, h_addr});
        check("hold_wdata", mem_wdata, h_wdata);
      end
      need = mem_instr ? prog[steps].fw : prog[steps].dw;
      data = mem_instr ? insn_word(steps) : prog[steps].rdata;
      rdy  = (waited >= need);
      mem_ready = rdy;
      mem_rdata = rdy ? data : $urandom;
      waited    = rdy ? 0 : waited + 1;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    if (core_step) begin
      check("step_spacing", prev_step, 0);
      check("step_gap", 64'(cyc - last_step_cyc), 64'(prog[steps].exp_cycles));
      check("step_retired", retired, 64'(steps));
      check("step_insn", core_insn, insn_word(steps));
      check("step_rdata", core_mem_rdata, prog[steps].exp_rdata);
      steps++;
      last_step_cyc = cyc;
      pc += 4;
    end
    prev_step = core_step;
  endtask

  // Holds reset over one edge, then checks the first post-reset cycle.
  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0; steps = 0; pc = 32'h0; waited = 0; prev_step = 1'b0; last_step_cyc = 1;
    cycle();
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", {mem_instr, mem_wstrb, mem_addr, mem_wdata}, 0);
    check("rst_insn", core_insn, NOP);
    check("rst_rdata", core_mem_rdata, 0);
    check("rst_retired", retired, 0);
    check("rst_flags", {halted, bus_error, core_step}, 0);
  endtask

  task automatic run_program(input int n, input string tag);
    int budget;
    do_reset();
    budget = 20;
    for (int i = 0; i < n; i++) budget += prog[i].exp_cycles;
    while (steps < n && budget > 0) begin
      cycle();
      budget--;
    end
    check({tag, "_done"}, 64'(steps), 64'(n));
    check({tag, "_no_halt"}, {halted, bus_error}, 0);
  endtask

  task automatic run_until_halt(output int hc);
    hc = -1;
    for (int i = 0; i < 30 && hc < 0; i++) begin
      cycle();
      if (halted) hc = cyc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hc;
    int          found;
    logic [31:0] last_rd;

    // Directed table: ALU, LW with waits, SW, and wait counts hitting the compare cycle.
    prog[0] = mk(KAlu,   0, 0, 32'h0,   32'h0,         32'h0,         4'h0,    3, 32'h0);
    prog[1] = mk(KLoad,  0, 2, 32'h200, 32'h0,         32'hDEAD_BEEF, 4'h0,    6, 32'hDEAD_BEEF);
    prog[2] = mk(KStore, 0, 0, 32'h100, 32'h1234_5678, 32'hBAD0_BAD0, 4'hF,    4, 32'hDEAD_BEEF);
    prog[3] = mk(KAlu,   1, 0, 32'h0,   32'h0,         32'h0,         4'h0,    4, 32'hDEAD_BEEF);
    prog[4] = mk(KLoad,  2, 0, 32'h44,  32'h0,         32'h0000_00A5, 4'h0,    6, 32'h0000_00A5);
    prog[5] = mk(KStore, 1, 3, 32'h1F0, 32'hCAFE_F00D, 32'h5555_5555, 4'b0011, 8, 32'h0000_00A5);
    prog[6] = mk(KAlu,   4, 0, 32'h0,   32'h0,         32'h0,         4'h0,    7, 32'h0000_00A5);
    prog[7] = mk(KLoad,  0, 4, 32'h80,  32'h0,         32'h0F0F_0000, 4'h0,    8, 32'h0F0F_0000);
    run_program(8, "table");

    // Random programs; expected gap is 3 cycles plus one per wait, plus one for a data phase.
    for (int r = 0; r < 3; r++) begin
      last_rd = 32'h0;
      for (int i = 0; i < 40; i++) begin
        int kind, fw, dw;
        logic [31:0] rd;
        kind = $urandom_range(0, 2);
        fw   = $urandom_range(0, 3);
        dw   = $urandom_range(0, 3);
        rd   = $urandom;
        if (kind == KLoad) last_rd = rd;
        prog[i] = mk(kind, fw, dw, $urandom & 32'hFFFF_FFFC, $urandom, rd,
                     (kind == KStore) ? 4'($urandom_range(1, 15)) : 4'h0,
                     3 + fw + ((kind != KAlu) ? 1 + dw : 0), last_rd);
      end
      run_program(40, "random");
    end

    // Trap after one committed instruction.
    prog[0] = mk(KAlu,  0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 3, 32'h0);
    prog[1] = mk(KTrap, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 3, 32'h0);
    do_reset();
    run_until_halt(hc);
    check("trap_halt_cycle", 64'(hc), 64'd7);
    check("trap_bus_error", bus_error, 0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("trap_idle", {mem_valid, core_step, halted}, 3'b001);
    end
    check("trap_retired", retired, 64'd1);

    // Fetch never answered: counter 0..4 over cycles 2..6, halt on cycle 7.
    prog[0] = mk(KAlu, 50, 0, 32'h0, 32'h0, 32'h0, 4'h0, 53, 32'h0);
    do_reset();
    run_until_halt(hc);
    check("tmo_halt_cycle", 64'(hc), 64'd7);
    check("tmo_bus_error", bus_error, 1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("tmo_idle", {mem_valid, halted, bus_error}, 3'b011);
    end
    check("tmo_retired", retired, 0);

    // Reset during a DATA wait abandons the load and restarts from the reset PC.
    prog[0] = mk(KAlu,  0, 0, 32'h0,   32'h0, 32'h0,         4'h0, 3, 32'h0);
    prog[1] = mk(KLoad, 0, 3, 32'h300, 32'h0, 32'h1111_2222, 4'h0, 7, 32'h1111_2222);
    do_reset();
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      cycle();
      if (steps == 1 && mem_valid && !mem_instr && waited >= 1) found = 1;
    end
    check("mid_reset_reached", 64'(found), 1);
    do_reset();
    for (int i = 0; i < 20 && steps < 1; i++) cycle();
    check("mid_reset_refetch", 64'(steps), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
